// File: rtl/ip_header_rx.sv
// ip_header_rx: validates an IPv4 header and forwards only the UDP datagram bytes
module ip_header_rx (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  datain,
  input  logic        data_en,
  input  logic [31:0] BOARD_IP,
  output logic [7:0]  dataout,
  output logic        udp_en,
  output logic [31:0] PC_IP,
  output logic [15:0] ip_len,
  output logic        hdr_err
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;
  state_t state, nxt;
  logic        armed, err_n, accept, bad, ours;
  logic [15:0] cnt, tot, acc, fold, hdr_len;
  logic [16:0] sum;
  logic [13:0] frag;
  logic [7:0]  vi, hi, proto;
  logic [31:0] src, dst, dst_now;
  assign hdr_len = {10'd0, vi[3:0], 2'b00};
  assign sum     = {1'b0, cnt == 16'd1 ? 16'd0 : acc} + {1'b0, hi, datain};
  assign fold    = sum[15:0] + {15'd0, sum[16]};
  assign dst_now = cnt == 16'd19 ? {dst[23:0], datain} : dst;
  assign bad     = vi[7:4] != 4'd4 || fold != 16'hFFFF || tot < hdr_len + 16'd8;
  assign ours    = proto == 8'd17 && !frag[13] && frag[12:0] == 13'd0 &&
                   (dst_now == BOARD_IP || dst_now == 32'hFFFF_FFFF);
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  // next state, decision at the header's last byte (byte 3 when IHL is too small)
  always_comb begin
    nxt    = state;
    err_n  = 1'b0;
    accept = 1'b0;
    if (!data_en) nxt = IDLE;
    else
      case (state)
        IDLE:    nxt = armed ? HDR : IDLE;
        HDR:
          if (vi[3:0] < 4'd5) begin
            if (cnt == 16'd3) begin
              nxt   = DROP;
              err_n = 1'b1;
            end
          end else if (cnt == hdr_len - 16'd1) begin
            nxt    = !bad && ours ? PAYLOAD : DROP;
            err_n  = bad;
            accept = !bad && ours;
          end
        PAYLOAD: nxt = cnt == tot - 16'd1 ? DROP : PAYLOAD;
        default: nxt = state;
      endcase
  end
  // byte index; armed marks that the next data_en byte truly begins a frame
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt   <= 16'd0;
      armed <= 1'b0;
    end else begin
      cnt   <= !data_en ? 16'd0 : cnt == 16'hFFFF ? cnt : cnt + 16'd1;
      armed <= !data_en;
    end
  // header field capture and running checksum
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      vi    <= 8'd0;
      tot   <= 16'd0;
      frag  <= 14'd0;
      proto <= 8'd0;
      src   <= 32'd0;
      dst   <= 32'd0;
      hi    <= 8'd0;
      acc   <= 16'd0;
    end else if (data_en) begin
      if (cnt == 16'd0) vi <= datain;
      if (cnt == 16'd2) tot[15:8] <= datain;
      if (cnt == 16'd3) tot[7:0] <= datain;
      if (cnt == 16'd6) frag[13:8] <= datain[5:0];
      if (cnt == 16'd7) frag[7:0] <= datain;
      if (cnt == 16'd9) proto <= datain;
      if (cnt >= 16'd12 && cnt <= 16'd15) src <= {src[23:0], datain};
      if (cnt >= 16'd16 && cnt <= 16'd19) dst <= {dst[23:0], datain};
      if (cnt[0]) acc <= fold;
      else        hi  <= datain;
    end
  // registered outputs
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      dataout <= 8'd0;
      udp_en  <= 1'b0;
      hdr_err <= 1'b0;
      PC_IP   <= 32'd0;
      ip_len  <= 16'd0;
    end else begin
      dataout <= datain;
      udp_en  <= data_en && state == PAYLOAD;
      hdr_err <= err_n;
      if (accept) begin
        PC_IP  <= src;
        ip_len <= tot - hdr_len;
      end
    end
endmodule

// File: tb/tb_ip_header_rx.sv
// tb_ip_header_rx: randomized and directed frames checked against a frame-level model
module tb_ip_header_rx;
  localparam logic [31:0] BIP = 32'hC0A8010A;
  logic        clock = 1'b0, reset_n, data_en;
  logic [7:0]  datain, dataout;
  logic        udp_en, hdr_err;
  logic [31:0] PC_IP;
  logic [15:0] ip_len;
  ip_header_rx dut (.clock(clock), .reset_n(reset_n), .datain(datain), .data_en(data_en),
    .BOARD_IP(BIP), .dataout(dataout), .udp_en(udp_en), .PC_IP(PC_IP), .ip_len(ip_len),
    .hdr_err(hdr_err));
  always #5 clock = ~clock;
  int checks = 0, errors = 0, udp_cnt = 0, err_cnt = 0;
  logic        chk_en = 1'b0;
  logic [7:0]  frm [0:127];
  logic [7:0]  first_d, exp_dout = 8'd0, cur_d = 8'd0;
  logic        exp_udp = 1'b0, exp_err = 1'b0, cur_u = 1'b0, cur_e = 1'b0, cur_a = 1'b0;
  logic [31:0] exp_pc = 32'd0, cur_pc = 32'd0;
  logic [15:0] exp_len = 16'd0, cur_ln = 16'd0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h at %0t", nm, act, exp, $time);
    end
  endtask
  // compare DUT outputs with the model every cycle
  always @(negedge clock)
    if (chk_en && reset_n) begin
      chk("dataout", {24'd0, dataout}, {24'd0, exp_dout});
      chk("udp_en", {31'd0, udp_en}, {31'd0, exp_udp});
      chk("hdr_err", {31'd0, hdr_err}, {31'd0, exp_err});
      chk("PC_IP", PC_IP, exp_pc);
      chk("ip_len", {16'd0, ip_len}, {16'd0, exp_len});
      if (udp_en) begin
        if (udp_cnt == 0) first_d = dataout;
        udp_cnt++;
      end
      if (hdr_err) err_cnt++;
    end
  // one's-complement sum of the first nw header words, folded to 16 bits
  function automatic logic [15:0] csum(input int nw);
    int s;
    s = 0;
    for (int i = 0; i < nw; i++) s += int'({frm[2*i], frm[2*i+1]});
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return 16'(s);
  endfunction
  task automatic build(input int ihl, input int tot, input int len, input logic [7:0] proto,
                       input logic [15:0] frag, input logic [31:0] src, input logic [31:0] dst);
    logic [15:0] cs;
    for (int i = 0; i < len; i++) frm[i] = 8'($urandom);
    frm[0] = {4'h4, 4'(ihl)}; frm[1] = 8'h00;
    frm[2] = 8'(tot >> 8); frm[3] = 8'(tot);
    frm[6] = frag[15:8]; frm[7] = frag[7:0]; frm[8] = 8'd64; frm[9] = proto;
    frm[10] = 8'd0; frm[11] = 8'd0;
    frm[12] = src[31:24]; frm[13] = src[23:16]; frm[14] = src[15:8]; frm[15] = src[7:0];
    frm[16] = dst[31:24]; frm[17] = dst[23:16]; frm[18] = dst[15:8]; frm[19] = dst[7:0];
    cs = ~csum(ihl * 2);
    frm[10] = cs[15:8]; frm[11] = cs[7:0];
  endtask
  // present one byte; the outputs for the previous byte become the expectation
  task automatic drive(input logic [7:0] d, input logic en, input logic u, input logic e,
                       input logic a, input logic [31:0] pc, input logic [15:0] ln);
    @(posedge clock); #1;
    exp_dout = cur_d; exp_udp = cur_u; exp_err = cur_e;
    if (cur_a) begin exp_pc = cur_pc; exp_len = cur_ln; end
    datain = d; data_en = en;
    cur_d = d; cur_u = u; cur_e = e; cur_a = a; cur_pc = pc; cur_ln = ln;
  endtask
  // frame-level model: classify the whole header, then mark per-byte outcomes
  task automatic send_frame(input int len, input int cut, input int gap);
    int n, ihl, hl, tot, dec;
    logic mal, ours, hit;
    logic [31:0] src, dst;
    n   = cut < len ? cut : len;
    ihl = int'(frm[0][3:0]); hl = ihl * 4;
    tot = int'({frm[2], frm[3]});
    src = {frm[12], frm[13], frm[14], frm[15]};
    dst = {frm[16], frm[17], frm[18], frm[19]};
    if (ihl < 5) begin dec = 3; mal = 1'b1; end
    else begin
      dec = hl - 1;
      mal = frm[0][7:4] != 4'd4 || csum(ihl * 2) != 16'hFFFF || tot < hl + 8;
    end
    ours = frm[9] == 8'd17 && !frm[6][5] && {frm[6][4:0], frm[7]} == 13'd0 &&
           (dst == BIP || dst == 32'hFFFF_FFFF);
    hit = n > dec && !mal && ours;
    for (int k = 0; k < n; k++)
      drive(frm[k], 1'b1, hit && k > dec && k < tot, n > dec && mal && k == dec,
            hit && k == dec, src, 16'(tot - hl));
    for (int g = 0; g < gap; g++) drive(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    @(negedge clock); #1;
  endtask
  task automatic clr();
    udp_cnt = 0; err_cnt = 0;
  endtask
  initial begin
    reset_n = 1'b0; data_en = 1'b0; datain = 8'd0;
    repeat (3) @(posedge clock);
    #2;
    chk("rst dataout", {24'd0, dataout}, 32'd0);
    chk("rst udp_en", {31'd0, udp_en}, 32'd0);
    chk("rst hdr_err", {31'd0, hdr_err}, 32'd0);
    chk("rst PC_IP", PC_IP, 32'd0);
    chk("rst ip_len", {16'd0, ip_len}, 32'd0);
    reset_n = 1'b1; chk_en = 1'b1;
    // valid 20-byte header, 46-byte padded frame
    build(5, 36, 46, 8'd17, 16'h0000, 32'hC0A80101, BIP); clr();
    send_frame(46, 46, 2);
    chk("t1 udp cycles", udp_cnt, 16);
    chk("t1 first byte", {24'd0, first_d}, {24'd0, frm[20]});
    chk("t1 PC_IP", PC_IP, 32'hC0A80101);
    chk("t1 ip_len", {16'd0, ip_len}, 32'd16);
    chk("t1 hdr_err", err_cnt, 0);
    // checksum bit flipped
    frm[11] = frm[11] ^ 8'h01; clr();
    send_frame(46, 46, 2);
    chk("t2 udp cycles", udp_cnt, 0);
    chk("t2 hdr_err", err_cnt, 1);
    chk("t2 PC_IP", PC_IP, 32'hC0A80101);
    chk("t2 ip_len", {16'd0, ip_len}, 32'd16);
    // IHL 6 with options
    build(6, 32, 46, 8'd17, 16'h0000, 32'hC0A80102, BIP); clr();
    send_frame(46, 46, 2);
    chk("t3 udp cycles", udp_cnt, 8);
    chk("t3 first byte", {24'd0, first_d}, {24'd0, frm[24]});
    chk("t3 ip_len", {16'd0, ip_len}, 32'd8);
    // silent rejections
    for (int s = 0; s < 4; s++) begin
      build(5, 36, 46, s == 0 ? 8'd6 : 8'd17, s == 2 ? 16'h2000 : s == 3 ? 16'h0010 : 16'h0000,
            32'hC0A80103, s == 1 ? 32'hC0A80163 : BIP);
      clr();
      send_frame(46, 46, 2);
      chk("silent udp", udp_cnt, 0);
      chk("silent hdr_err", err_cnt, 0);
    end
    chk("silent PC_IP", PC_IP, 32'hC0A80102);
    // broadcast, truncated after 5 payload bytes, then back-to-back frame
    build(5, 36, 46, 8'd17, 16'h4000, 32'hC0A80104, 32'hFFFF_FFFF); clr();
    send_frame(46, 25, 1);
    chk("bcast udp cycles", udp_cnt, 5);
    chk("bcast PC_IP", PC_IP, 32'hC0A80104);
    build(5, 36, 46, 8'd17, 16'h0000, 32'hC0A80105, BIP); clr();
    send_frame(46, 46, 2);
    chk("b2b udp cycles", udp_cnt, 16);
    chk("b2b PC_IP", PC_IP, 32'hC0A80105);
    // asynchronous reset mid-payload
    build(5, 36, 46, 8'd17, 16'h0000, 32'h0A000001, BIP);
    send_frame(46, 25, 0);
    reset_n = 1'b0;
    #1;
    chk("arst dataout", {24'd0, dataout}, 32'd0);
    chk("arst udp_en", {31'd0, udp_en}, 32'd0);
    chk("arst hdr_err", {31'd0, hdr_err}, 32'd0);
    chk("arst PC_IP", PC_IP, 32'd0);
    chk("arst ip_len", {16'd0, ip_len}, 32'd0);
    exp_pc = 32'd0; exp_len = 16'd0; cur_u = 1'b0; cur_e = 1'b0; cur_a = 1'b0;
    #1 reset_n = 1'b1;
    clr();
    for (int k = 25; k < 46; k++) drive(frm[k], 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    drive(8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    @(negedge clock); #1;
    chk("post-rst udp", udp_cnt, 0);
    build(5, 40, 50, 8'd17, 16'h0000, 32'h0A000002, BIP); clr();
    send_frame(50, 50, 2);
    chk("post-rst udp cycles", udp_cnt, 20);
    chk("post-rst PC_IP", PC_IP, 32'h0A000002);
    // randomized frames
    for (int it = 0; it < 60; it++) begin
      int ihl, hl, len, tot, r, cut;
      logic [31:0] dst;
      ihl = int'($urandom_range(5, 7)); hl = ihl * 4;
      len = int'($urandom_range(hl + 10, 90));
      tot = ($urandom_range(0, 5) == 0) ? hl + int'($urandom_range(0, 7))
                                        : int'($urandom_range(hl + 8, len));
      r = int'($urandom_range(0, 3));
      dst = r < 2 ? BIP : r == 2 ? 32'hFFFF_FFFF : $urandom;
      build(ihl, tot, len, ($urandom_range(0, 3) == 0) ? 8'd6 : 8'd17,
            ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'h4000, $urandom, dst);
      r = int'($urandom_range(0, 9));
      if (r == 0) frm[$urandom_range(0, hl - 1)] ^= 8'(1 << $urandom_range(0, 7));
      if (r == 1) frm[0][7:4] = 4'h6;
      if (r == 2) frm[0][3:0] = 4'($urandom_range(0, 4));
      cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, len)) : len;
      send_frame(len, cut, int'($urandom_range(1, 3)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
